sdram_host_master: RTL and testbench

Synchronous bus master that drives the micro-side interface of the SDRAM host controller (`mp_*` strobes, address, data, mode-set, busy) from a simple valid/ready request port. It lets on-chip logic such as a DMA engine, BIST or boot loader issue single SDRAM reads, writes and mode-register writes without a microprocessor. All strobes are generated from counters clocked by `sys_clk`, and `sdram_busy_l` is synchronised before use.

---
 rtl/sdram_host_master.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_host_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_master.sv
// Bus master for the SDRAM host controller micro port: turns single valid/ready
// requests into registered mp_* strobe sequences timed from sys_clk counters.
module sdram_host_master #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_mode,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] mp_addx,
  output logic [15:0] mp_data_out,
  input  logic [15:0] mp_data_in,
  output logic        mp_rd_l,
  output logic        mp_wr_l,
  output logic        mp_cs_l,
  output logic        sdram_mode_set_l,
  input  logic        sdram_busy_l,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising clock edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. rsp_valid is a
  // one-cycle pulse with no back-pressure, qualified by rsp_timeout.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_NB = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ABORT   = 3'd7;

  localparam int PW = 8;
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYC - 1);
  localparam logic [9:0]    TO_LAST    = 10'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          bsync1_q, bsync2_q;
  logic          busy_s;
  logic [19:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          we_q, mode_q;
  logic          accept;
  logic          rd_capture;
  logic          cs_act, wr_act, rd_act, mode_act;

  logic          cs_l_q, rd_l_q, wr_l_q, mode_l_q;
  logic [19:0]   mp_addx_q;
  logic [15:0]   mp_data_out_q;
  logic          rsp_valid_q, rsp_timeout_q, req_ready_q;
  logic [15:0]   rsp_rdata_q;

  // Synchroniser idles at "not busy" so busy_s comes out of reset low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bsync1_q <= 1'b1;
      bsync2_q <= 1'b1;
    end else begin
      bsync1_q <= sdram_busy_l;
      bsync2_q <= bsync1_q;
    end
  end

  assign busy_s     = ~bsync2_q;
  assign accept     = (state_q == S_IDLE) && req_valid;
  assign rd_capture = (state_q == S_RD_WAIT) && !busy_s;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT_NB;
          cnt_d   = '0;
        end
      end
      S_WAIT_NB: begin
        if (!busy_s) begin
          state_d = S_SETUP;
          ph_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d = S_STROBE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (ph_q == PULSE_LAST) begin
          ph_d  = '0;
          cnt_d = '0;
          state_d = we_q ? S_HOLD : S_RD_WAIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!busy_s) begin
          state_d = S_HOLD;
          ph_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_HOLD: begin
        if (ph_q == HOLD_LAST) begin
          state_d = S_DONE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe levels are decoded from the next state and registered, so every
  // mp_* output changes exactly on a clock edge.
  always_comb begin
    cs_act   = (state_d == S_SETUP) || (state_d == S_STROBE) ||
               (state_d == S_RD_WAIT) || (state_d == S_HOLD);
    wr_act   = (state_d == S_STROBE) && we_q;
    rd_act   = ((state_d == S_STROBE) || (state_d == S_RD_WAIT)) && !we_q;
    mode_act = mode_q && ((state_d == S_SETUP) || (state_d == S_STROBE) ||
                          (state_d == S_HOLD));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mode write is always a write, whatever req_we says.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we | req_mode;
      mode_q  <= req_mode;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_l_q        <= 1'b1;
      rd_l_q        <= 1'b1;
      wr_l_q        <= 1'b1;
      mode_l_q      <= 1'b1;
      mp_addx_q     <= '0;
      mp_data_out_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      req_ready_q   <= 1'b1;
    end else begin
      cs_l_q        <= ~cs_act;
      rd_l_q        <= ~rd_act;
      wr_l_q        <= ~wr_act;
      mode_l_q      <= ~mode_act;
      rsp_valid_q   <= (state_d == S_DONE) || (state_d == S_ABORT);
      rsp_timeout_q <= (state_d == S_ABORT);
      req_ready_q   <= (state_d == S_IDLE);
      if ((state_q == S_WAIT_NB) && (state_d == S_SETUP)) begin
        mp_addx_q     <= addr_q;
        mp_data_out_q <= wdata_q;
      end
      if (state_d == S_ABORT) begin
        rsp_rdata_q <= '0;
      end else if (rd_capture) begin
        rsp_rdata_q <= mp_data_in;
      end
    end
  end

  assign mp_cs_l          = cs_l_q;
  assign mp_rd_l          = rd_l_q;
  assign mp_wr_l          = wr_l_q;
  assign sdram_mode_set_l = mode_l_q;
  assign mp_addx          = mp_addx_q;
  assign mp_data_out      = mp_data_out_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign req_ready        = req_ready_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sdram_host_master.sv
// Bench for sdram_host_master: directed and random requests against a
// cycle-count model of the strobe sequence and a simple busy/data controller.
module tb_sdram_host_master;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int TO = 1023;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_mode = 1'b0;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] mp_addx;
  logic [15:0] mp_data_out;
  logic [15:0] mp_data_in;
  logic        mp_rd_l, mp_wr_l, mp_cs_l, sdram_mode_set_l;
  logic        sdram_busy_l;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Controller model: holds busy for ctl_b cycles after mp_rd_l falls and
  // presents inverted data while busy, the real word once idle.
  int          ctl_b = 0;
  logic [15:0] ctl_data = '0;
  logic        ctl_busy = 1'b0;
  int          ctl_cnt = 0;
  logic        prev_rd = 1'b1;
  logic        ext_busy = 1'b0;

  assign sdram_busy_l = ~(ctl_busy | ext_busy);
  assign mp_data_in   = ctl_busy ? ~ctl_data : ctl_data;

  sdram_host_master dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_mode         (req_mode),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_timeout      (rsp_timeout),
    .mp_addx          (mp_addx),
    .mp_data_out      (mp_data_out),
    .mp_data_in       (mp_data_in),
    .mp_rd_l          (mp_rd_l),
    .mp_wr_l          (mp_wr_l),
    .mp_cs_l          (mp_cs_l),
    .sdram_mode_set_l (sdram_mode_set_l),
    .sdram_busy_l     (sdram_busy_l),
    .dbg_state        (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (prev_rd && !mp_rd_l) begin
      ctl_cnt  = ctl_b;
      ctl_busy = (ctl_b > 0);
    end else if (ctl_cnt > 0) begin
      ctl_cnt = ctl_cnt - 1;
      if (ctl_cnt == 0) ctl_busy = 1'b0;
    end
    prev_rd = mp_rd_l;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request from a negedge to the negedge after its response.
  // ext_rel > 0: external busy already held, released at negedge ext_rel.
  task automatic do_txn(input logic is_we, input logic is_mode, input logic [19:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int b, input int ext_rel);
    logic eff_we, abort;
    int setup_edge, wn, w, lat, cs_exp, rd_exp, wr_exp, md_exp;
    int n, got_n, cs_n, wr_n, rd_n, md_n, first_cs, viol, rdy_viol;
    logic p_cs, p_rd, p_wr;
    logic [19:0] seen_addx;
    logic [15:0] seen_dout, got_rdata;
    logic got_to;

    eff_we     = is_we | is_mode;
    setup_edge = (ext_rel > 0) ? ext_rel + 2 : 1;
    abort      = 1'b0;
    if (eff_we) begin
      w      = 0;
      cs_exp = S + P + H;
      wr_exp = P;
      rd_exp = 0;
      lat    = setup_edge + S + P + H + 1;
    end else begin
      // Synchroniser adds two cycles to the busy window seen after the pulse.
      wn = b + 3 - P;
      if (wn < 1) wn = 1;
      if (wn - 1 >= TO) begin
        abort  = 1'b1;
        w      = TO;
        cs_exp = S + P + TO;
        lat    = setup_edge + S + P + TO + 1;
      end else begin
        w      = wn;
        cs_exp = S + P + w + H;
        lat    = setup_edge + S + P + w + H + 1;
      end
      wr_exp = 0;
      rd_exp = P + w;
    end
    md_exp = is_mode ? S + P + H : 0;

    ctl_b    = b;
    ctl_data = rdata;
    chk("ready_in", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = is_we;
    req_mode  = is_mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
    req_addr  = 20'($urandom);
    req_wdata = 16'($urandom);
    req_we    = 1'($urandom);
    req_mode  = 1'b0;

    got_n = 0; cs_n = 0; wr_n = 0; rd_n = 0; md_n = 0; first_cs = 0;
    viol = 0; rdy_viol = 0; p_cs = 1'b1; p_rd = 1'b1; p_wr = 1'b1;
    seen_addx = '0; seen_dout = '0; got_rdata = '0; got_to = 1'b0;
    for (n = 1; n <= lat + 20; n++) begin
      if (ext_rel > 0 && n == ext_rel) ext_busy = 1'b0;
      if (!mp_cs_l) begin
        cs_n++;
        if (first_cs == 0) begin
          first_cs  = n;
          seen_addx = mp_addx;
          seen_dout = mp_data_out;
        end
      end
      if (!mp_wr_l) wr_n++;
      if (!mp_rd_l) rd_n++;
      if (!sdram_mode_set_l) md_n++;
      if (p_cs && !mp_cs_l && ((p_rd && !mp_rd_l) || (p_wr && !mp_wr_l))) viol++;
      if (!p_cs && mp_cs_l && ((!p_rd && mp_rd_l) || (!p_wr && mp_wr_l))) viol++;
      if (req_ready) rdy_viol++;
      p_cs = mp_cs_l; p_rd = mp_rd_l; p_wr = mp_wr_l;
      if (rsp_valid) begin
        got_n     = n;
        got_rdata = rsp_rdata;
        got_to    = rsp_timeout;
        break;
      end
      @(negedge sys_clk);
    end
    ext_busy = 1'b0;

    chk("latency", got_n, lat);
    chk("cs_low_cycles", cs_n, cs_exp);
    chk("wr_low_cycles", wr_n, wr_exp);
    chk("rd_low_cycles", rd_n, rd_exp);
    chk("mode_low_cycles", md_n, md_exp);
    chk("rsp_timeout", got_to, abort);
    chk("mp_addx", seen_addx, addr);
    chk("mp_data_out", seen_dout, wdata);
    chk("busy_ready", rdy_viol, 0);
    if (!eff_we) chk("rsp_rdata", got_rdata, abort ? 16'h0 : rdata);
    if (!abort) chk("strobe_order", viol, 0);
    if (ext_rel > 0) chk("ser_gap", first_cs - ext_rel, 3);
    @(negedge sys_clk);
    chk("rsp_pulse", rsp_valid, 1'b0);
    chk("ready_back", req_ready, 1'b1);
    chk("strobes_idle", {mp_cs_l, mp_rd_l, mp_wr_l, sdram_mode_set_l}, 4'hF);
  endtask

  initial begin
    int op, gap, rsp_seen;

    repeat (3) @(negedge sys_clk);
    chk("rst_cs", mp_cs_l, 1'b1);
    chk("rst_rd", mp_rd_l, 1'b1);
    chk("rst_wr", mp_wr_l, 1'b1);
    chk("rst_mode", sdram_mode_set_l, 1'b1);
    chk("rst_addx", mp_addx, 20'h0);
    chk("rst_dout", mp_data_out, 16'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_ready", req_ready, 1'b1);

    do_txn(1'b1, 1'b0, 20'h12345, 16'hA5A5, 16'h0000, 0, 0);
    do_txn(1'b0, 1'b0, 20'h00ABC, 16'h1111, 16'h3C3C, 12, 0);
    do_txn(1'($urandom), 1'b1, 20'h00000, 16'h0020, 16'h0000, 0, 0);

    // Controller still busy from an earlier write: 3 cycles before, 17 after.
    ext_busy = 1'b1;
    repeat (3) @(negedge sys_clk);
    do_txn(1'b1, 1'b0, 20'hFEDCB, 16'h5A5A, 16'h0000, 0, 17);

    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 2);
      do_txn(op == 1, op == 2, 20'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 15), 0);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge sys_clk);
    end

    do_txn(1'b0, 1'b0, 20'h0BEEF, 16'h2222, 16'h7E7E, 1100, 0);
    repeat (100) @(negedge sys_clk);
    do_txn(1'b1, 1'b0, 20'h54321, 16'hC3C3, 16'h0000, 0, 0);

    // Reset in the middle of a write pulse.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 20'h0F0F0;
    req_wdata = 16'h9999;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!mp_wr_l) break;
      @(negedge sys_clk);
    end
    chk("pre_rst_wr", mp_wr_l, 1'b0);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_strobes", {mp_cs_l, mp_rd_l, mp_wr_l, sdram_mode_set_l}, 4'hF);
    chk("midrst_rsp", rsp_valid, 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("postrst_ready", req_ready, 1'b1);
    rsp_seen = 0;
    repeat (15) begin
      if (rsp_valid) rsp_seen++;
      @(negedge sys_clk);
    end
    chk("postrst_no_rsp", rsp_seen, 0);
    chk("postrst_cs", mp_cs_l, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
